// File: rtl/xnor_pop_pkg.sv
// Shared definitions for the streaming XNOR-popcount neuron engine.
//
// Contents:
//   POP_W(n)       width needed to hold a popcount of n bits ($clog2(n)+1)
//   SUM_W_DEFAULT  default accumulator / threshold width
//   CMP_MODE_GT    compare encoding: out_bit = sum >  thr
//   CMP_MODE_GE    compare encoding: out_bit = sum >= thr
package xnor_pop_pkg;

  localparam int SUM_W_DEFAULT = 16;

  localparam int CMP_MODE_GT = 0;
  localparam int CMP_MODE_GE = 1;

  function automatic int POP_W(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/xnor_popcount_tree.sv
// Pipelined XNOR + popcount tree.
//
// The N-bit chunk is XNORed, split into groups of up to 16 bits, and each group
// is counted. With POP_STAGES == 1 the group counts are summed and registered
// once. With POP_STAGES >= 2 the group counts are registered first, summed into
// a second register, and any further stages are plain delay registers.
// A generic sideband bus travels alongside the data with identical latency.
//
// Ports:
//   clk       in   1          clock
//   rstn      in   1          synchronous, active-high reset (clears sideband only)
//   en        in   1          advance enable; all stages hold when low
//   xi, wi    in   N          activation / weight chunk
//   side      in   SB_W       sideband captured with the chunk
//   pop       out  POP_W(N)   popcount of ~(xi ^ wi), POP_STAGES cycles later
//   pop_side  out  SB_W       sideband aligned with pop
module xnor_popcount_tree
  import xnor_pop_pkg::*;
#(
  parameter int N          = 256,
  parameter int POP_STAGES = 2,
  parameter int SB_W       = 1
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 en,
  input  logic [N-1:0]         xi,
  input  logic [N-1:0]         wi,
  input  logic [SB_W-1:0]      side,
  output logic [POP_W(N)-1:0]  pop,
  output logic [SB_W-1:0]      pop_side
);

  localparam int PW   = POP_W(N);
  localparam int GRP  = (N < 16) ? N : 16;
  localparam int G    = (N + GRP - 1) / GRP;
  localparam int PADW = G * GRP;
  localparam int GW   = POP_W(GRP);

  logic [N-1:0]      match;
  logic [PADW-1:0]   match_pad;
  logic [G*GW-1:0]   parts_flat;

  assign match     = ~(xi ^ wi);
  // Zero padding so the last group may be partial without counting phantom bits.
  assign match_pad = PADW'(match);

  function automatic logic [PW-1:0] sum_parts(input logic [G*GW-1:0] v);
    logic [PW-1:0] s;
    s = '0;
    for (int g = 0; g < G; g++) begin
      s = s + PW'(v[g*GW +: GW]);
    end
    return s;
  endfunction

  genvar gi;

  generate
    for (gi = 0; gi < G; gi++) begin : g_grp
      logic [GW-1:0] cnt;
      always_comb begin
        cnt = '0;
        for (int b = 0; b < GRP; b++) begin
          cnt = cnt + GW'(match_pad[gi*GRP + b]);
        end
      end
      assign parts_flat[gi*GW +: GW] = cnt;
    end
  endgenerate

  // Sideband chain: only these registers carry reset, since the valid flag
  // lives here and the data registers are meaningless without it.
  logic [SB_W-1:0] side_q [POP_STAGES];

  always_ff @(posedge clk) begin
    if (rstn) begin
      for (int k = 0; k < POP_STAGES; k++) begin
        side_q[k] <= '0;
      end
    end else if (en) begin
      side_q[0] <= side;
      for (int k = 1; k < POP_STAGES; k++) begin
        side_q[k] <= side_q[k-1];
      end
    end
  end

  assign pop_side = side_q[POP_STAGES-1];

  generate
    if (POP_STAGES == 1) begin : g_one
      logic [PW-1:0] pop_q;
      always_ff @(posedge clk) begin
        if (en) begin
          pop_q <= sum_parts(parts_flat);
        end
      end
      assign pop = pop_q;
    end else begin : g_multi
      logic [G*GW-1:0] part_reg;
      logic [PW-1:0]   pop_q [POP_STAGES-1];

      always_ff @(posedge clk) begin
        if (en) begin
          part_reg <= parts_flat;
          pop_q[0] <= sum_parts(part_reg);
          for (int k = 1; k < POP_STAGES - 1; k++) begin
            pop_q[k] <= pop_q[k-1];
          end
        end
      end
      assign pop = pop_q[POP_STAGES-2];
    end
  endgenerate

endmodule

// File: rtl/xnor_popcount_stream.sv
// Streaming binary-neuron engine.
//
// Accepts a vector as a sequence of N-bit chunks over a valid/ready handshake,
// popcounts ~(xi ^ wi) for each chunk through a pipelined tree, accumulates the
// counts with saturation, and on the last chunk compares the total against the
// threshold sampled with that chunk and emits one result.
//
// Ports:
//   clk        in   1      clock
//   rstn       in   1      synchronous, active-high reset
//   in_valid   in   1      chunk beat valid
//   in_ready   out  1      engine can accept a beat
//   in_last    in   1      beat is the final chunk of its vector
//   xi         in   N      activation chunk
//   wi         in   N      weight chunk
//   ti         in   SUM_W  threshold, used only from the last beat
//   out_valid  out  1      result valid
//   out_ready  in   1      downstream accepts result
//   out_bit    out  1      neuron output (sum > thr, or sum >= thr when CMP_GE=1)
//   out_sum    out  SUM_W  final accumulated popcount
//   out_sat    out  1      accumulator saturated during this vector
module xnor_popcount_stream
  import xnor_pop_pkg::*;
#(
  parameter int N          = 256,
  parameter int SUM_W      = SUM_W_DEFAULT,
  parameter int POP_STAGES = 2,
  parameter int CMP_GE     = 0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_last,
  input  logic [N-1:0]     xi,
  input  logic [N-1:0]     wi,
  input  logic [SUM_W-1:0] ti,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_bit,
  output logic [SUM_W-1:0] out_sum,
  output logic             out_sat
);

  localparam int PW    = POP_W(N);
  localparam int EXT_W = ((SUM_W > PW) ? SUM_W : PW) + 1;
  localparam int SB_W  = SUM_W + 2;
  localparam logic [EXT_W-1:0] SUM_MAX = {{(EXT_W-SUM_W){1'b0}}, {SUM_W{1'b1}}};

  logic adv;
  logic accept;

  logic [PW-1:0]   pop;
  logic [SB_W-1:0] side;
  logic [SB_W-1:0] pop_side;

  logic             a_valid;
  logic             a_last;
  logic [SUM_W-1:0] a_ti;

  logic             out_valid_reg;
  logic             out_bit_reg;
  logic [SUM_W-1:0] out_sum_reg;
  logic             out_sat_reg;
  logic [SUM_W-1:0] acc_reg;
  logic             sat_acc_reg;

  logic [EXT_W-1:0] sum_ext;
  logic             overflow;
  logic [SUM_W-1:0] acc_next;
  logic             cmp_bit;

  // The whole pipeline moves only when the output register can take a result,
  // so a stalled result back-pressures every stage at once.
  assign adv      = ~out_valid_reg | out_ready;
  assign in_ready = adv & ~rstn;
  assign accept   = in_valid & in_ready;

  assign side = {accept, in_last, ti};

  xnor_popcount_tree #(
    .N          (N),
    .POP_STAGES (POP_STAGES),
    .SB_W       (SB_W)
  ) u_tree (
    .clk      (clk),
    .rstn     (rstn),
    .en       (adv),
    .xi       (xi),
    .wi       (wi),
    .side     (side),
    .pop      (pop),
    .pop_side (pop_side)
  );

  assign a_valid = pop_side[SB_W-1];
  assign a_last  = pop_side[SB_W-2];
  assign a_ti    = pop_side[SUM_W-1:0];

  always_comb begin
    sum_ext  = EXT_W'(acc_reg) + EXT_W'(pop);
    overflow = (sum_ext > SUM_MAX);
    acc_next = overflow ? {SUM_W{1'b1}} : sum_ext[SUM_W-1:0];
    if (CMP_GE == CMP_MODE_GE) begin
      cmp_bit = (acc_next >= a_ti);
    end else begin
      cmp_bit = (acc_next > a_ti);
    end
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      out_valid_reg <= 1'b0;
      out_bit_reg   <= 1'b0;
      out_sum_reg   <= '0;
      out_sat_reg   <= 1'b0;
      acc_reg       <= '0;
      sat_acc_reg   <= 1'b0;
    end else if (adv) begin
      // adv implies any held result is being consumed (or none is held).
      out_valid_reg <= 1'b0;
      if (a_valid) begin
        if (a_last) begin
          out_valid_reg <= 1'b1;
          out_bit_reg   <= cmp_bit;
          out_sum_reg   <= acc_next;
          out_sat_reg   <= sat_acc_reg | overflow;
          acc_reg       <= '0;
          sat_acc_reg   <= 1'b0;
        end else begin
          acc_reg       <= acc_next;
          sat_acc_reg   <= sat_acc_reg | overflow;
        end
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign out_bit   = out_bit_reg;
  assign out_sum   = out_sum_reg;
  assign out_sat   = out_sat_reg;

endmodule

// File: tb/tb_xnor_popcount_stream.sv
// Directed bench for xnor_popcount_stream. Three instances share one stimulus:
// the default (N=256, SUM_W=16, greater-than), a CMP_GE=1 instance and a
// SUM_W=9 instance. They stay in lockstep because their handshakes are equal.
module tb_xnor_popcount_stream;

  typedef struct packed {
    logic        b;
    logic [15:0] sum;
    logic        sat;
  } res_t;

  logic         clk = 1'b0;
  logic         rstn;
  logic         in_valid;
  logic         in_last;
  logic [255:0] xi;
  logic [255:0] wi;
  logic [15:0]  ti;
  logic [8:0]   ti9;
  logic         out_ready;

  logic         in_ready_a, out_valid_a, out_bit_a, out_sat_a;
  logic [15:0]  out_sum_a;
  logic         in_ready_g, out_valid_g, out_bit_g, out_sat_g;
  logic [15:0]  out_sum_g;
  logic         in_ready_s, out_valid_s, out_bit_s, out_sat_s;
  logic [8:0]   out_sum_s;

  int tests_run    = 0;
  int tests_failed = 0;
  bit t3_done;
  bit t6_done;

  res_t q_a[$];
  res_t q_g[$];
  res_t q_s[$];

  assign ti9 = ti[8:0];

  always #5 clk = ~clk;

  xnor_popcount_stream #(.N(256), .SUM_W(16), .POP_STAGES(2), .CMP_GE(0)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready_a), .in_last(in_last),
    .xi(xi), .wi(wi), .ti(ti), .out_valid(out_valid_a), .out_ready(out_ready),
    .out_bit(out_bit_a), .out_sum(out_sum_a), .out_sat(out_sat_a)
  );

  xnor_popcount_stream #(.N(256), .SUM_W(16), .POP_STAGES(2), .CMP_GE(1)) dut_ge (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready_g), .in_last(in_last),
    .xi(xi), .wi(wi), .ti(ti), .out_valid(out_valid_g), .out_ready(out_ready),
    .out_bit(out_bit_g), .out_sum(out_sum_g), .out_sat(out_sat_g)
  );

  xnor_popcount_stream #(.N(256), .SUM_W(9), .POP_STAGES(2), .CMP_GE(0)) dut_s9 (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready_s), .in_last(in_last),
    .xi(xi), .wi(wi), .ti(ti9), .out_valid(out_valid_s), .out_ready(out_ready),
    .out_bit(out_bit_s), .out_sum(out_sum_s), .out_sat(out_sat_s)
  );

  function automatic res_t mk(input logic b, input logic [15:0] s, input logic sat);
    res_t r;
    r.b   = b;
    r.sum = s;
    r.sat = sat;
    return r;
  endfunction

  // A result transfers at the next rising edge; inputs only change after edges.
  always @(negedge clk) begin
    if (!rstn && out_ready) begin
      if (out_valid_a) q_a.push_back(mk(out_bit_a, out_sum_a, out_sat_a));
      if (out_valid_g) q_g.push_back(mk(out_bit_g, out_sum_g, out_sat_g));
      if (out_valid_s) q_s.push_back(mk(out_bit_s, {7'd0, out_sum_s}, out_sat_s));
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int qsize(input int inst);
    case (inst)
      0:       return q_a.size();
      1:       return q_g.size();
      default: return q_s.size();
    endcase
  endfunction

  task automatic clear_q();
    q_a.delete();
    q_g.delete();
    q_s.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  // Drives one beat whose XNOR popcount is p; xi is random so each beat differs.
  task automatic send_beat(input int p, input logic last, input logic [15:0] t);
    logic [255:0] r;
    logic [255:0] m;
    bit acc;
    int n;
    for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
    m = '0;
    for (int k = 0; k < p; k++) m[k] = 1'b1;
    xi = r;
    wi = r ^ ~m;
    in_last  = last;
    ti       = t;
    in_valid = 1'b1;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 500) begin
      @(negedge clk);
      acc = in_ready_a;
      @(posedge clk);
      #1;
      n++;
    end
    check("accept", acc, 1);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic expect_res(input string tag, input int inst,
                            input logic b, input int s, input logic sat);
    res_t r;
    int n;
    n = 0;
    while (qsize(inst) == 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check({tag, ":avail"}, (qsize(inst) != 0), 1);
    if (qsize(inst) == 0) return;
    case (inst)
      0:       r = q_a.pop_front();
      1:       r = q_g.pop_front();
      default: r = q_s.pop_front();
    endcase
    $display("[TB] %s: bit=%0d sum=%0d sat=%0d (want %0d/%0d/%0d)",
             tag, r.b, r.sum, r.sat, b, s, sat);
    check({tag, ":bit"}, r.b, b);
    check({tag, ":sum"}, r.sum, s);
    check({tag, ":sat"}, r.sat, sat);
  endtask

  // Popcounts 100, 50, 0, 256 with junk thresholds on the non-last beats.
  task automatic run_t2(input bit gaps);
    send_beat(100, 1'b0, 16'd999);
    if (gaps) idle($urandom_range(0, 3));
    send_beat(50, 1'b0, 16'd7);
    if (gaps) idle($urandom_range(0, 3));
    send_beat(0, 1'b0, 16'd0);
    if (gaps) idle($urandom_range(0, 3));
    send_beat(256, 1'b1, 16'd406);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn      = 1'b1;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    xi        = '0;
    wi        = '0;
    ti        = '0;
    out_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst:in_ready", in_ready_a, 0);
    check("rst:out_valid", out_valid_a, 0);
    check("rst:out_sum", out_sum_a, 0);
    check("rst:out_bit", out_bit_a, 0);
    check("rst:out_sat", out_sat_a, 0);
    step();
    rstn = 1'b0;
    @(negedge clk);
    check("rst:in_ready_after", in_ready_a, 1);
    step();

    // Test 1: single full-match beat, latency 3 cycles
    send_beat(256, 1'b1, 16'd255);
    @(negedge clk);
    check("t1:lat_c1", out_valid_a, 0);
    @(negedge clk);
    check("t1:lat_c2", out_valid_a, 0);
    @(negedge clk);
    check("t1:lat_c3", out_valid_a, 1);
    expect_res("t1", 0, 1'b1, 256, 1'b0);
    expect_res("t1_ge", 1, 1'b1, 256, 1'b0);
    idle(6);
    clear_q();

    // Test 2: four beats summing to 406 against threshold 406
    run_t2(1'b0);
    expect_res("t2_gt", 0, 1'b0, 406, 1'b0);
    expect_res("t2_ge", 1, 1'b1, 406, 1'b0);
    expect_res("t2_s9", 2, 1'b0, 406, 1'b0);
    idle(6);
    clear_q();

    // Test 3: back-to-back single beats with the output stalled
    out_ready = 1'b0;
    t3_done   = 1'b0;
    fork
      begin
        for (int i = 1; i <= 5; i++) send_beat(i, 1'b1, 16'd2);
        t3_done = 1'b1;
      end
      begin
        int n;
        n = 0;
        while (!out_valid_a && n < 50) begin
          @(negedge clk);
          n++;
        end
        check("t3:valid_seen", out_valid_a, 1);
        repeat (5) begin
          @(negedge clk);
          check("t3:stall_in_ready", in_ready_a, 0);
          check("t3:stall_valid", out_valid_a, 1);
          check("t3:stall_sum", out_sum_a, 1);
          check("t3:stall_bit", out_bit_a, 0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    check("t3:driver_done", t3_done, 1);
    expect_res("t3_v1", 0, 1'b0, 1, 1'b0);
    expect_res("t3_v2", 0, 1'b0, 2, 1'b0);
    expect_res("t3_v3", 0, 1'b1, 3, 1'b0);
    expect_res("t3_v4", 0, 1'b1, 4, 1'b0);
    expect_res("t3_v5", 0, 1'b1, 5, 1'b0);
    idle(6);
    clear_q();

    // Test 4: saturation on the 9-bit accumulator, then a clean vector
    send_beat(256, 1'b0, 16'd0);
    send_beat(256, 1'b0, 16'd0);
    send_beat(256, 1'b1, 16'd100);
    send_beat(3, 1'b1, 16'd5);
    expect_res("t4_s9_sat", 2, 1'b1, 511, 1'b1);
    expect_res("t4_s9_clean", 2, 1'b0, 3, 1'b0);
    expect_res("t4_wide", 0, 1'b1, 768, 1'b0);
    expect_res("t4_wide_clean", 0, 1'b0, 3, 1'b0);
    idle(6);
    clear_q();

    // Test 5: reset mid-vector discards the partial sum
    send_beat(200, 1'b0, 16'd0);
    send_beat(200, 1'b0, 16'd0);
    rstn = 1'b1;
    @(negedge clk);
    check("t5:rst_in_ready", in_ready_a, 0);
    step();
    rstn = 1'b0;
    send_beat(10, 1'b1, 16'd5);
    expect_res("t5", 0, 1'b1, 10, 1'b0);
    idle(10);
    check("t5:no_stale", q_a.size(), 0);
    clear_q();

    // Test 6: test 2 replayed with random gaps and random out_ready
    t6_done = 1'b0;
    fork
      begin
        repeat (3) run_t2(1'b1);
        t6_done = 1'b1;
      end
      begin
        while (!t6_done) begin
          @(posedge clk);
          #1;
          out_ready = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
      end
    join
    for (int i = 0; i < 3; i++) begin
      expect_res($sformatf("t6_gt_%0d", i), 0, 1'b0, 406, 1'b0);
      expect_res($sformatf("t6_ge_%0d", i), 1, 1'b1, 406, 1'b0);
    end
    idle(10);
    check("t6:no_extra", q_a.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
